stream_data_packer: RTL

Transmit-side counterpart of the stream data parser. It collects result streams from `CORES` processing cores and round-robin arbitrates between them. For each packet it writes one 512-bit header word (length, id) into the send FIFO, followed by exactly `length` 512-bit payload beats, so the downstream host link receives the same framing the parser consumes on the receive side.

---
 rtl/stream_data_packer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/stream_data_packer.sv
// Round-robin packer: frames result streams from CORES cores as a header word plus payload beats into the send FIFO.
// Optional `STREAM_DATA_PACKER_EOP_CHECK_EN` enables the sticky eop/length consistency check.
module stream_data_packer #(
  parameter int CORES      = 4,
  parameter int FIFO_DEPTH = 2048,
  parameter int HEADROOM   = 4,
  localparam int IDX_W     = (CORES > 1) ? $clog2(CORES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CORES-1:0]     src_req,
  input  logic [32*CORES-1:0]  src_length,
  input  logic [32*CORES-1:0]  src_stream_id,
  input  logic [CORES-1:0]     src_valid,
  input  logic [CORES-1:0]     src_eop,
  input  logic [512*CORES-1:0] src_data,
  output logic [CORES-1:0]     src_grant,
  output logic [CORES-1:0]     src_ready,
  output logic                 send_fifo_wrreq,
  output logic [511:0]         send_fifo_data,
  input  logic [10:0]          send_fifo_wrusedw,
  output logic                 busy,
  output logic [IDX_W-1:0]     cur_core,
  output logic                 err_eop_mismatch
);

  localparam int DATA_W = 512;
  localparam logic [11:0] SPACE_LIMIT = 12'(FIFO_DEPTH - HEADROOM);

  typedef enum logic [1:0] {IDLE, HEADER, BODY} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  last_core;
  logic [IDX_W-1:0]  pick;
  logic [31:0]       len_q, id_q, remain;
  logic              space_ok, accept, last_beat, hdr_wr, grant_now;
  logic [DATA_W-1:0] beat_data;
  logic              vld_p1;
  logic [DATA_W-1:0] wr_data_p1;

  // First requester at or after last+1, wrapping; the previous winner has lowest priority.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [CORES-1:0] req,
                                                input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] sel;
    int idx;
    sel = last;
    for (int k = CORES; k >= 1; k--) begin
      idx = (int'(last) + k) % CORES;
      if (req[idx]) sel = IDX_W'(idx);
    end
    return sel;
  endfunction

  assign space_ok  = {1'b0, send_fifo_wrusedw} < SPACE_LIMIT;
  assign pick      = rr_pick(src_req, last_core);
  assign grant_now = (state == IDLE) && (|src_req);
  assign hdr_wr    = (state == HEADER) && space_ok;
  assign accept    = (state == BODY) && space_ok && src_valid[cur_core];
  assign last_beat = (remain == 32'd1);
  assign beat_data = src_data[int'(cur_core)*DATA_W +: DATA_W];
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    src_ready = '0;
    case (state)
      IDLE:    if (|src_req) state_nxt = HEADER;
      HEADER:  if (space_ok) state_nxt = (len_q == 32'd0) ? IDLE : BODY;
      BODY: begin
        src_ready[cur_core] = space_ok;
        if (accept && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_core <= IDX_W'(CORES - 1);
      cur_core  <= '0;
      src_grant <= '0;
      remain    <= '0;
    end else begin
      state     <= state_nxt;
      src_grant <= '0;
      if (grant_now) begin
        src_grant <= CORES'(1) << pick;
        cur_core  <= pick;
        last_core <= pick;
        remain    <= src_length[int'(pick)*32 +: 32];
      end else if (accept) begin
        remain    <= remain - 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant_now) begin
      len_q <= src_length[int'(pick)*32 +: 32];
      id_q  <= src_stream_id[int'(pick)*32 +: 32];
    end
  end

  // Write stage: header or accepted beat lands in the FIFO one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      wr_data_p1 <= '0;
    end else begin
      vld_p1 <= hdr_wr || accept;
      if (hdr_wr)      wr_data_p1 <= {448'd0, id_q, len_q};
      else if (accept) wr_data_p1 <= beat_data;
    end
  end

  assign send_fifo_wrreq = vld_p1;
  assign send_fifo_data  = wr_data_p1;

`ifdef STREAM_DATA_PACKER_EOP_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset)                                           err_q <= 1'b0;
    else if (accept && (src_eop[cur_core] != last_beat)) err_q <= 1'b1;
  end
  assign err_eop_mismatch = err_q;
`else
  logic unused_eop;
  assign unused_eop       = ^src_eop;
  assign err_eop_mismatch = 1'b0;
`endif

endmodule
